// File: rtl/arb_mux_n_to_1.sv
// rtl/arb_mux_n_to_1.sv - round-robin, packet-locking N:1 stream mux with registered output
module arb_mux_n_to_1 #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_ptr_nxt;
  logic [SW-1:0] lock_idx;
  logic [SW-1:0] lock_idx_nxt;

  logic [SW-1:0] gnt_idx;
  logic          gnt_found;
  logic [W-1:0]  gnt_data;
  logic          gnt_last;
  logic          load_en;
  logic          xfer;
  int            scan_idx;
  logic [SW-1:0] cand;

  // Candidate lane: the locked lane mid-packet, else first valid lane at or after rr_ptr (wrapping)
  always_comb begin
    gnt_idx   = rr_ptr;
    gnt_found = 1'b0;
    scan_idx  = 0;
    cand      = '0;
    if (state == ST_LOCKED) begin
      gnt_idx   = lock_idx;
      gnt_found = in_valid[lock_idx];
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= N) begin
          scan_idx = scan_idx - N;
        end
        cand = SW'(scan_idx);
        if (!gnt_found && in_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // Handshake: the output register may take a beat when empty or draining this cycle
  always_comb begin
    gnt_data = in_data[gnt_idx*W +: W];
    gnt_last = in_last[gnt_idx];
    load_en  = !out_valid || out_ready;
    xfer     = rst_n && load_en && gnt_found;
    in_ready = xfer ? (N'(1) << gnt_idx) : '0;
  end

  // Arbiter next state: lock on a non-last beat, release and advance rr_ptr on a last beat
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    if (xfer) begin
      if (gnt_last) begin
        state_nxt  = ST_IDLE;
        rr_ptr_nxt = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
      end else begin
        state_nxt    = ST_LOCKED;
        lock_idx_nxt = gnt_idx;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Output register: load on input transfer, empty on drain without refill, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_last  <= gnt_last;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_n_to_1.sv
// tb/tb_arb_mux_n_to_1.sv - scoreboard bench for arb_mux_n_to_1
module tb_arb_mux_n_to_1;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  typedef struct { logic [W-1:0] data; logic last; } beat_t;
  typedef struct { int sel; logic [W-1:0] data; logic last; } exp_t;
  typedef struct { int sel; logic [W-1:0] data; int cyc; } log_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [SW-1:0] out_sel;
  logic          out_ready;

  arb_mux_n_to_1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t lane_q[N][$];
  exp_t  sb[$];
  exp_t  want[$];
  log_t  dlog[$];
  exp_t  pend;
  bit    pend_v = 0;
  int    m_lock = -1;
  int    m_rr   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the scoreboard holds exactly what the output register should hold
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("out_valid", out_valid, 64'(sb.size() != 0));
        if (out_valid === 1'b1 && sb.size() != 0) begin
          chk("out_sel", out_sel, sb[0].sel);
          chk("out_data", out_data, sb[0].data);
          chk("out_last", out_last, sb[0].last);
          if (out_ready) begin
            dlog.push_back('{sb[0].sel, sb[0].data, cyc});
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic drive_lanes(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      in_valid[i] = en[i] && (lane_q[i].size() != 0);
      in_data[i*W +: W] = in_valid[i] ? lane_q[i][0].data : W'($urandom);
      in_last[i] = in_valid[i] ? lane_q[i][0].last : 1'($urandom);
    end
  endtask

  task automatic cycle(input logic [N-1:0] en, input logic ordy);
    logic [N-1:0] exp_rdy;
    bit ld;
    bit found;
    int g;
    int l;
    @(posedge clk);
    #1;
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    drive_lanes(en);
    out_ready = ordy;
    #1;
    ld = (sb.size() == 0) || ordy;
    found = 0;
    g = 0;
    if (m_lock >= 0) begin
      g = m_lock;
      found = in_valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        l = (m_rr + k) % N;
        if (!found && in_valid[l]) begin
          found = 1;
          g = l;
        end
      end
    end
    exp_rdy = '0;
    if (ld && found) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    if (ld && found) begin
      pend = '{g, lane_q[g][0].data, lane_q[g][0].last};
      pend_v = 1;
      if (lane_q[g][0].last) begin
        m_lock = -1;
        m_rr = (g + 1) % N;
      end else begin
        m_lock = g;
      end
      void'(lane_q[g].pop_front());
    end
  endtask

  task automatic run(input int n, input logic [N-1:0] en, input logic ordy);
    for (int i = 0; i < n; i++) cycle(en, ordy);
  endtask

  task automatic do_reset(input logic [N-1:0] en);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    out_ready = 1'b0;
    pend_v = 0;
    drive_lanes(en);
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_in_reset2", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    sb.delete();
    dlog.delete();
    want.delete();
    m_lock = -1;
    m_rr = 0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    in_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic add_beat(input int lane, input logic [W-1:0] d, input logic last);
    lane_q[lane].push_back('{d, last});
  endtask

  task automatic check_log(input string name, input bit no_bubble);
    chk({name, "_count"}, dlog.size(), want.size());
    for (int k = 0; k < want.size() && k < dlog.size(); k++) begin
      chk({name, "_sel"}, dlog[k].sel, want[k].sel);
      chk({name, "_data"}, dlog[k].data, want[k].data);
      if (no_bubble && k > 0) chk({name, "_gap"}, dlog[k].cyc - dlog[k-1].cyc, 1);
    end
    want.delete();
    dlog.delete();
  endtask

  initial begin
    bit done;
    int len;
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    in_last = '0;
    out_ready = 1'b0;

    // Reset state, idle inputs
    do_reset('0);
    run(2, '0, 1'b1);

    // Single-beat packets on lanes 0,3,7
    do_reset('0);
    for (int r = 0; r < 2; r++) begin
      add_beat(0, 8'hA0, 1'b1);
      add_beat(3, 8'hA3, 1'b1);
      add_beat(7, 8'hA7, 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      want.push_back('{0, 8'hA0, 1'b1});
      want.push_back('{3, 8'hA3, 1'b1});
      want.push_back('{7, 8'hA7, 1'b1});
    end
    run(8, '1, 1'b1);
    check_log("rr_0_3_7", 1'b1);

    // Lane 2 three-beat packet locks out lane 5
    do_reset('0);
    add_beat(2, 8'h11, 1'b0);
    add_beat(2, 8'h22, 1'b0);
    add_beat(2, 8'h33, 1'b1);
    add_beat(5, 8'h55, 1'b1);
    want.push_back('{2, 8'h11, 1'b0});
    want.push_back('{2, 8'h22, 1'b0});
    want.push_back('{2, 8'h33, 1'b1});
    want.push_back('{5, 8'h55, 1'b1});
    run(7, '1, 1'b1);
    check_log("lock_lane2", 1'b1);

    // Backpressure for 4 cycles holding 8'h5C
    do_reset('0);
    add_beat(0, 8'h5C, 1'b1);
    add_beat(1, 8'h61, 1'b1);
    cycle(8'h01, 1'b1);
    for (int s = 0; s < 4; s++) begin
      cycle(8'h03, 1'b0);
      chk("stall_data", out_data, 8'h5C);
      chk("stall_in_ready", in_ready, 0);
    end
    want.push_back('{0, 8'h5C, 1'b1});
    want.push_back('{1, 8'h61, 1'b1});
    run(4, 8'h03, 1'b1);
    check_log("stall", 1'b0);

    // All lanes valid continuously, single-beat
    do_reset('0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        add_beat(i, W'(i * 16 + r), 1'b1);
        want.push_back('{i, W'(i * 16 + r), 1'b1});
      end
    run(18, '1, 1'b1);
    check_log("all_lanes", 1'b1);

    // Reset mid-packet on lane 4
    do_reset('0);
    add_beat(4, 8'h41, 1'b0);
    add_beat(4, 8'h42, 1'b0);
    add_beat(4, 8'h43, 1'b1);
    run(2, '1, 1'b1);
    do_reset(8'h10);
    add_beat(1, 8'h11, 1'b1);
    add_beat(4, 8'h44, 1'b1);
    want.push_back('{1, 8'h11, 1'b1});
    want.push_back('{4, 8'h44, 1'b1});
    run(4, 8'h12, 1'b1);
    check_log("after_reset", 1'b1);

    // Randomized traffic
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int ln;
        ln = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) add_beat(ln, W'($urandom), b == len - 1);
      end
      cycle(N'($urandom), $urandom_range(0, 3) != 0);
    end
    done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      cycle('1, 1'b1);
      done = (sb.size() == 0) && !pend_v;
      for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) done = 0;
    end
    chk("flush_done", done, 1);
    run(2, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux_n_to_1.md
ARB_MUX_N_TO_1 -- requirements
Module: arb_mux_n_to_1

Interface
REQ-001 Parameter N, default 8, number of input lanes; SHALL be >= 2.
REQ-002 Parameter W, default 8, data width per lane.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  N  per-lane beat valid.
REQ-006 in_data  input  N*W  lane i data at bits [i*W +: W].
REQ-007 in_last  input  N  per-lane last-beat-of-packet flag.
REQ-008 in_ready  output  N  per-lane accept; at most one bit set.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  W  registered beat data.
REQ-011 out_last  output  1  registered last flag.
REQ-012 out_sel  output  $clog2(N)  registered source lane index of current beat.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Transfer on an input lane SHALL occur when in_valid[i] && in_ready[i]; on the output when out_valid && out_ready.
REQ-015 Output register SHALL be loadable ("load_en") when out_valid==0 or out_ready==1 in the same cycle.
REQ-016 in_ready SHALL be combinational: one-hot of the granted lane when load_en and that lane's in_valid are both 1, else all zeros.
REQ-017 Arbiter states: IDLE (no packet locked) and LOCKED (packet in progress on lane lock_idx).
REQ-018 In IDLE, grant SHALL be the first lane with in_valid set, searching from rr_ptr upward with wrap N-1 -> 0.
REQ-019 In LOCKED, grant SHALL be lock_idx only; other lanes receive in_ready=0 regardless of in_valid.
REQ-020 On an input transfer with in_last=0, state SHALL become LOCKED with lock_idx = granted lane.
REQ-021 On an input transfer with in_last=1, state SHALL become IDLE and rr_ptr SHALL become (granted lane + 1) mod N.
REQ-022 rr_ptr SHALL change only on a last-beat transfer; single-beat packets (in_last=1 on first beat) never enter LOCKED.
REQ-023 On an input transfer, out_data, out_last, out_sel SHALL load the granted lane's data/last/index next edge and out_valid SHALL be 1.
REQ-024 Output drained (out_ready=1) with no input transfer that cycle SHALL clear out_valid next edge; out_data/out_last/out_sel hold.
REQ-025 Simultaneous drain and load SHALL sustain one beat per cycle with no bubble.
REQ-026 out_valid=1 with out_ready=0 SHALL hold out_data/out_last/out_sel stable and force in_ready to zero.
REQ-027 Latency input transfer -> out_valid SHALL be exactly 1 cycle.
REQ-028 No beat SHALL be duplicated, dropped or reordered within a lane; packets from different lanes SHALL never interleave.
REQ-029 If no lane is valid, in_ready SHALL be zero and state/rr_ptr SHALL hold.

Reset
REQ-030 While rst_n==0 at an edge: out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, rr_ptr=0, lock_idx=0.
REQ-031 While rst_n==0, in_ready SHALL be all zeros.
REQ-032 Reset mid-packet or with out_valid=1 SHALL discard the held beat and lock; first grant after release follows REQ-018 from lane 0.

Verification
REQ-033 After reset, in_valid=8'h00 -> out_valid=0, in_ready=8'h00, out_sel=0.
REQ-034 Lanes 0,3,7 valid with single-beat packets (in_last=1, data 8'hA0/8'hA3/8'hA7), out_ready=1 -> outputs in order sel 0,3,7, data A0,A3,A7, one per cycle, then 0 again if still valid.
REQ-035 Lane 2 sends 3-beat packet (11,22,33, last on 33) while lane 5 valid throughout -> lane 5 in_ready=0 until beat 33 transfers; next output beat from sel 5.
REQ-036 out_ready=0 for 4 cycles with out_valid=1, data 8'h5C -> out_data stays 8'h5C, in_ready=8'h00; out_ready=1 resumes flow without loss.
REQ-037 All 8 lanes valid continuously, single-beat, out_ready=1 -> 16 cycles produce sel sequence 0..7,0..7, no bubble.
REQ-038 rst_n asserted mid-packet on lane 4 (beat 2 of 3) -> next edge out_valid=0, state IDLE; after release, lane 1 and lane 4 valid -> lane 1 granted first.
